ps2_key_ctrl: RTL and testbench
===============================

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, width of press_count.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 scan_code  input  8  byte at head of keyboard receiver FIFO.
REQ-005 ready  input  1  receiver FIFO non-empty.
REQ-006 overflow  input  1  receiver FIFO overflow flag.
REQ-007 nextdata_n  output  1  active-low pop strobe to receiver, registered.
REQ-008 key_valid  output  1  one-cycle pulse, key event valid.
REQ-009 key_code  output  8  event scan code, held until next event.
REQ-010 key_ext  output  1  event carried E0 prefix.
REQ-011 key_break  output  1  1 = release event, 0 = press event.
REQ-012 key_held  output  1  a non-prefix key is currently pressed (last make not yet released).
REQ-013 press_count  output  CNT_W  count of emitted press events.
REQ-014 ovf_err  output  1  sticky, receiver overflow seen.

Function
REQ-015 Fetch FSM states: IDLE, POP, SETTLE; IDLE->POP when ready=1, else stay; POP->SETTLE; SETTLE->IDLE, unconditionally.
REQ-016 On the IDLE->POP edge, latch scan_code into byte register and register nextdata_n=0, so nextdata_n is low for exactly the POP cycle.
REQ-017 nextdata_n is 1 in all other cycles; at most one pop per byte; max one byte per 3 cycles.
REQ-018 A latched byte is decoded in the POP cycle; all decode outputs update on the POP->SETTLE edge.
REQ-019 Byte 8'hE0: set ext flag, no event.
REQ-020 Byte 8'hF0: set brk flag, no event; ext flag kept.
REQ-021 Byte 8'hE1: emit press event key_code=8'hE1, key_ext=0, key_break=0; then load skip counter=7, and the next 7 bytes are popped and discarded without decode.
REQ-022 Any other byte: emit event with key_code=byte, key_ext=ext flag, key_break=brk flag; then clear both flags.
REQ-023 key_valid is high for exactly one cycle per emitted event.
REQ-024 Held-key register {ext, code}: updated with the event's {ext, code} on a press event; key_held set to 1.
REQ-025 Release event whose {ext, code} matches the held-key register clears key_held; a non-matching release leaves key_held unchanged.
REQ-026 press_count increments by 1 per emitted press event, wraps modulo 2^CNT_W; release events do not count.
REQ-027 ovf_err set when overflow=1 on any edge; cleared only by reset.
REQ-028 Prefix flags and skip counter persist across idle gaps of any length (no timeout).
REQ-029 Consecutive prefixes accumulate: E0,E0,xx -> ext=1; F0,F0,xx -> break=1.

Reset
REQ-030 While rst_n=0: state=IDLE, nextdata_n=1, key_valid=0, key_code=8'h00, key_ext=0, key_break=0, key_held=0, press_count=0, ovf_err=0, flags=0, skip counter=0, held-key register=0.
REQ-031 Reset asserted mid-sequence (in POP, or between prefix and code) discards the partial sequence; the first byte after release is decoded as a fresh sequence.
REQ-032 After rst_n deasserts, the first pop does not occur before the second rising edge.

Configuration
REQ-033 Macro PS2_TYPEMATIC_FILTER_EN defined: press event with {ext, code} equal to the held-key register while key_held=1 is suppressed (no key_valid, no press_count increment); byte still popped.
REQ-034 Macro PS2_TYPEMATIC_FILTER_EN undefined: every press event, including auto-repeat, is emitted and counted.

Verification
REQ-035 FIFO supplies 8'h1C -> nextdata_n low exactly 1 cycle; key_valid pulse with key_code=1C, ext=0, break=0; press_count=1; key_held=1.
REQ-036 Bytes F0,1C after 1C press -> one event key_code=1C, break=1; key_held=0; press_count unchanged.
REQ-037 Bytes E0,75 then E0,F0,75 -> press event ext=1 code=75, then release event ext=1 break=1 code=75; two key_valid pulses total.
REQ-038 Bytes 1C,1C,1C with macro defined -> one key_valid, press_count=1; macro undefined -> three key_valid, press_count=3.
REQ-039 Bytes E1,14,77,E1,F0,14,F0,77 -> 8 pops, single event code=E1; then byte 1C decodes normally.
REQ-040 overflow pulsed 1 cycle -> ovf_err=1 until rst_n low; rst_n low after lone F0, then 1C -> press event, break=0.

Source files
------------

// File: rtl/ps2_key_ctrl_if.sv
// PS/2 key controller bus: receiver FIFO head/handshake plus decoded key events.
// master = the key controller, slave = the receiver/consumer side.
interface ps2_key_ctrl_if #(
  parameter int CNT_W = 8
);
  // receiver FIFO side
  logic [7:0]       scan_code;
  logic             ready;
  logic             overflow;
  logic             nextdata_n;
  // decoded event side
  logic             key_valid;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_break;
  logic             key_held;
  logic [CNT_W-1:0] press_count;
  logic             ovf_err;

  modport master (
    input  scan_code, ready, overflow,
    output nextdata_n, key_valid, key_code, key_ext, key_break,
           key_held, press_count, ovf_err
  );

  modport slave (
    output scan_code, ready, overflow,
    input  nextdata_n, key_valid, key_code, key_ext, key_break,
           key_held, press_count, ovf_err
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code set 2 key controller.
// Pops bytes from the keyboard receiver FIFO (one per 3 cycles max), folds
// E0/F0 prefixes into flags, swallows the 7 trailing bytes of the E1 Pause
// sequence, and emits one key_valid pulse per press/release event.
// Optional build macro PS2_TYPEMATIC_FILTER_EN: drop auto-repeat presses of
// the key that is already held.
module ps2_key_ctrl #(
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  ps2_key_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } state_e;

  localparam logic [7:0] B_EXT   = 8'hE0;
  localparam logic [7:0] B_BRK   = 8'hF0;
  localparam logic [7:0] B_PAUSE = 8'hE1;

  // fetch FSM
  state_e           state_q, state_d;
  logic             armed_q;
  logic [7:0]       byte_q, byte_d;
  logic             nextdata_n_q, nextdata_n_d;

  // decode state
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic [2:0]       skip_q, skip_d;
  logic [8:0]       hreg_q, hreg_d;
  logic             held_q, held_d;

  // event outputs
  logic             valid_q, valid_d;
  logic [7:0]       code_q, code_d;
  logic             kext_q, kext_d;
  logic             kbrk_q, kbrk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q;

  // event candidate produced by the byte decoder
  logic             ev_fire;
  logic             ev_ext;
  logic             ev_brk;
  logic [7:0]       ev_code;
  logic             suppress;

  // Fetch FSM next state: pop at most one byte, then settle one cycle so the
  // receiver has time to advance its head before we look at ready again.
  // armed_q delays the first pop to the second edge after reset release.
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    nextdata_n_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (armed_q && bus.ready) begin
          state_d      = POP;
          byte_d       = bus.scan_code;
          nextdata_n_d = 1'b0;
        end
      end
      POP:     state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fetch FSM registers; nextdata_n is registered so it is low for exactly
  // the POP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      armed_q      <= 1'b0;
      byte_q       <= 8'h00;
      nextdata_n_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      armed_q      <= 1'b1;
      byte_q       <= byte_d;
      nextdata_n_q <= nextdata_n_d;
    end
  end

  // Byte decoder: prefixes update flags, Pause loads the skip counter,
  // anything else becomes a press/release event candidate.
  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    skip_d  = skip_q;
    ev_fire = 1'b0;
    ev_ext  = 1'b0;
    ev_brk  = 1'b0;
    ev_code = 8'h00;
    if (state_q == POP) begin
      if (skip_q != 3'd0) begin
        // tail of the Pause sequence: popped but never decoded
        skip_d = skip_q - 3'd1;
      end else begin
        case (byte_q)
          B_EXT: ext_d = 1'b1;
          B_BRK: brk_d = 1'b1;
          B_PAUSE: begin
            ev_fire = 1'b1;
            ev_code = B_PAUSE;
            skip_d  = 3'd7;
          end
          default: begin
            ev_fire = 1'b1;
            ev_ext  = ext_q;
            ev_brk  = brk_q;
            ev_code = byte_q;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
          end
        endcase
      end
    end
  end

  // Auto-repeat filter: a press of the key already held is a typematic repeat.
`ifdef PS2_TYPEMATIC_FILTER_EN
  assign suppress = held_q && (hreg_q == {ev_ext, ev_code});
`else
  assign suppress = 1'b0;
`endif

  // Event application: drive the event outputs, track the held key and
  // count presses. Outputs hold their last event until the next one.
  always_comb begin
    valid_d = 1'b0;
    code_d  = code_q;
    kext_d  = kext_q;
    kbrk_d  = kbrk_q;
    hreg_d  = hreg_q;
    held_d  = held_q;
    cnt_d   = cnt_q;
    if (ev_fire) begin
      if (ev_brk) begin
        valid_d = 1'b1;
        code_d  = ev_code;
        kext_d  = ev_ext;
        kbrk_d  = 1'b1;
        // only releasing the held key clears key_held
        if (hreg_q == {ev_ext, ev_code}) held_d = 1'b0;
      end else if (!suppress) begin
        valid_d = 1'b1;
        code_d  = ev_code;
        kext_d  = ev_ext;
        kbrk_d  = 1'b0;
        hreg_d  = {ev_ext, ev_code};
        held_d  = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  // Decode and event registers; everything updates on the POP->SETTLE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      skip_q  <= 3'd0;
      hreg_q  <= 9'h000;
      held_q  <= 1'b0;
      valid_q <= 1'b0;
      code_q  <= 8'h00;
      kext_q  <= 1'b0;
      kbrk_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      skip_q  <= skip_d;
      hreg_q  <= hreg_d;
      held_q  <= held_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      kext_q  <= kext_d;
      kbrk_q  <= kbrk_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sticky receiver-overflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_q | bus.overflow;
  end

  assign bus.nextdata_n  = nextdata_n_q;
  assign bus.key_valid   = valid_q;
  assign bus.key_code    = code_q;
  assign bus.key_ext     = kext_q;
  assign bus.key_break   = kbrk_q;
  assign bus.key_held    = held_q;
  assign bus.press_count = cnt_q;
  assign bus.ovf_err     = ovf_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: a queue-based receiver FIFO feeds bytes, a
// keystroke-level model predicts the event stream, press count and held state.
module tb_ps2_key_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_key_ctrl_if #(.CNT_W(CNT_W)) bus ();
  ps2_key_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] fifo[$];
  logic [9:0] obs[$];
  logic [9:0] exp_q[$];
  int pushed = 0;
  int pops = 0;
  int pop_anom = 0;
  int vld_anom = 0;
  int since = 1000;
  logic vld_prev = 1'b0;

  // reference model state
  logic       m_ext, m_brk, m_held;
  int         m_skip, m_cnt;
  logic [8:0] m_hreg;

  logic [7:0] codes [6] = '{8'h1C, 8'h75, 8'h14, 8'h77, 8'h29, 8'h5A};

  // receiver FIFO head presented on the falling edge
  always @(negedge clk) begin
    bus.ready     = (fifo.size() != 0);
    bus.scan_code = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  // receiver advances its head when it sees the pop strobe
  always @(posedge clk)
    if (rst_n && bus.nextdata_n === 1'b0 && fifo.size() != 0) void'(fifo.pop_front());

  // output monitor
  always @(negedge clk) begin
    if (bus.key_valid === 1'b1) obs.push_back({bus.key_ext, bus.key_break, bus.key_code});
    if (vld_prev && bus.key_valid === 1'b1) vld_anom++;
    vld_prev = (bus.key_valid === 1'b1);
    if (bus.nextdata_n === 1'b0) begin
      pops++;
      if (since < 2) pop_anom++;
      since = 0;
    end else if (since < 1000) since++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = 0; m_skip = 0; m_cnt = 0; m_hreg = '0;
  endtask

  task automatic model_event(input logic e, input logic k, input logic [7:0] c);
    if (k) begin
      exp_q.push_back({e, 1'b1, c});
      if (m_hreg == {e, c}) m_held = 0;
    end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (m_held && m_hreg == {e, c}) return;
`endif
      exp_q.push_back({e, 1'b0, c});
      m_cnt  = (m_cnt + 1) % (1 << CNT_W);
      m_hreg = {e, c};
      m_held = 1;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1) begin model_event(1'b0, 1'b0, 8'hE1); m_skip = 7; end
    else begin model_event(m_ext, m_brk, b); m_ext = 0; m_brk = 0; end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo.push_back(b);
    pushed++;
    model_byte(b);
  endtask

  task automatic drain();
    int n = 0;
    while (fifo.size() != 0 && n < 3000) begin cyc(1); n++; end
    chk("drain timeout", (n >= 3000), 0);
    cyc(4);
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, " event count"}, obs.size(), exp_q.size());
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, " event"}, obs[i], exp_q[i]);
    if (exp_q.size() != 0)
      chk({tag, " held outputs"}, {bus.key_ext, bus.key_break, bus.key_code}, exp_q[exp_q.size()-1]);
    chk({tag, " press_count"}, bus.press_count, m_cnt);
    chk({tag, " key_held"}, bus.key_held, m_held);
    chk({tag, " pops"}, pops, pushed);
    obs.delete();
    exp_q.delete();
  endtask

  task automatic seq(input logic [7:0] b[$], input string tag);
    foreach (b[i]) push_byte(b[i]);
    drain();
    compare(tag);
  endtask

  // one random keystroke at the make/break/pause level
  task automatic keystroke();
    int r = $urandom_range(0, 9);
    logic [7:0] c = codes[$urandom_range(0, 5)];
    if (r <= 4) begin
      if ($urandom_range(0, 2) == 0) begin
        push_byte(8'hE0);
        if ($urandom_range(0, 4) == 0) push_byte(8'hE0);
      end
      push_byte(c);
    end else if (r <= 8) begin
      if ($urandom_range(0, 2) == 0) push_byte(8'hE0);
      push_byte(8'hF0);
      if ($urandom_range(0, 4) == 0) push_byte(8'hF0);
      push_byte(c);
    end else begin
      push_byte(8'hE1);
      repeat (7) push_byte(8'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    bus.overflow = 1'b0;
    model_reset();
    rst_n = 1'b0;
    cyc(3);
    chk("reset nextdata_n", bus.nextdata_n, 1);
    chk("reset key_valid", bus.key_valid, 0);
    chk("reset key_code", bus.key_code, 0);
    chk("reset key_ext", bus.key_ext, 0);
    chk("reset key_break", bus.key_break, 0);
    chk("reset key_held", bus.key_held, 0);
    chk("reset press_count", bus.press_count, 0);
    chk("reset ovf_err", bus.ovf_err, 0);

    // byte waiting while in reset must not be popped until the second edge
    push_byte(8'h1C);
    cyc(2);
    chk("no pop in reset", bus.nextdata_n, 1);
    rst_n = 1'b1;
    cyc(1);
    chk("no pop at first edge", bus.nextdata_n, 1);
    drain();
    compare("single press 1C");

    seq('{8'hF0, 8'h1C}, "release 1C");
    seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75}, "extended 75");
    seq('{8'h1C, 8'h1C, 8'h1C}, "typematic 1C");
    seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C}, "pause then 1C");
    seq('{8'hF0, 8'hF0, 8'h29}, "double break prefix");

    // prefix survives a long idle gap
    push_byte(8'hE0);
    drain();
    cyc(60);
    seq('{8'h5A}, "prefix across gap");

    // overflow pulse makes ovf_err sticky
    bus.overflow = 1'b1;
    cyc(1);
    bus.overflow = 1'b0;
    cyc(5);
    chk("ovf_err sticky", bus.ovf_err, 1);

    // reset between prefix and code discards the prefix
    seq('{8'hF0}, "lone break prefix");
    rst_n = 1'b0;
    model_reset();
    cyc(2);
    chk("ovf_err cleared by reset", bus.ovf_err, 0);
    chk("press_count cleared by reset", bus.press_count, 0);
    rst_n = 1'b1;
    cyc(2);
    seq('{8'h1C}, "fresh after reset");

    // random keystroke streams with occasional idle gaps
    for (int round = 0; round < 8; round++) begin
      for (int k = 0; k < 12; k++) begin
        keystroke();
        if ($urandom_range(0, 3) == 0) cyc($urandom_range(0, 20));
      end
      drain();
      compare("random stream");
    end

    chk("nextdata_n one cycle, spaced", pop_anom, 0);
    chk("key_valid single-cycle", vld_anom, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
